udp_rx_parser: RTL
==================

// Module: udp_rx_parser
// PURPOSE
//  Receive-side header parser that feeds the 8->32 packer with UDP payload bytes.
//  Consumes the MAC byte stream (no preamble/SFD, FCS still attached) and checks Ethernet II, IPv4 and UDP headers.
//  Filters on local MAC/IP/port and emits only the datagram payload as data_out/udp_data_valid.
//  Also exports source IP/port and payload length.
// PARAMETERS
//  LOCAL_MAC   48'h02_00_00_00_00_01  accepted dest MAC (broadcast FF..FF also accepted)
//  LOCAL_IP    32'hC0A8_0164          accepted dest IPv4 address (192.168.1.100)
//  LOCAL_PORT  16'd5000               accepted UDP dest port
//  CHECK_CSUM  1                      1: drop frames whose IPv4 header checksum fails; 0: skip the check
// PORTS
//  aclk            in   1   clock
//  aresetn         in   1   asynchronous reset, active low
//  rx_data         in   8   frame byte from MAC
//  rx_valid        in   1   high for every byte of a frame, contiguous; low for >=1 cycle between frames
//  data_out        out  8   payload byte to packer
//  udp_data_valid  out  1   payload byte strobe, contiguous per datagram
//  udp_src_ip      out  32  source IP of current/last accepted datagram
//  udp_src_port    out  16  source port of current/last accepted datagram
//  udp_pay_len     out  16  UDP length - 8 of current/last accepted datagram
//  frame_drop      out  1   1-cycle pulse per rejected or truncated frame
// BEHAVIOUR
//  Reset (async, aresetn low): all outputs 0; state IDLE; byte counter 0; checksum accumulator 0.
//  States: IDLE -> ETH_HDR -> IP_HDR -> UDP_HDR -> PAYLOAD -> DRAIN; DROP.
//   IDLE:    first rx_valid byte is dest MAC byte 0; go to ETH_HDR with counter = 1.
//   ETH_HDR: 14 bytes. dest MAC must equal LOCAL_MAC or broadcast. Ethertype (bytes 12-13) must be 16'h0800.
//   IP_HDR:  20 bytes. Byte 0 must be 8'h45 (IHL != 5 rejected).
//            Flags MF = 0 and fragment offset = 0 required. Protocol = 17. Dest IP = LOCAL_IP.
//            Total length captured. Src IP latched into a shadow register.
//   Checksum: 16-bit words summed big-endian, ones-complement with end-around carry.
//            Valid iff final sum == 16'hFFFF (only checked when CHECK_CSUM=1).
//   UDP_HDR: 8 bytes. Dest port = LOCAL_PORT. UDP length L must satisfy 8 <= L <= total_length - 20.
//            UDP checksum ignored.
//   Acceptance: on the last UDP_HDR byte, shadow src IP/port and L-8 are copied to the udp_* outputs.
//            If L == 8: go to DRAIN with no payload strobe. Otherwise go to PAYLOAD.
//   PAYLOAD: forward exactly L-8 bytes. data_out/udp_data_valid are registered: 1-cycle latency from the rx byte.
//            Trailing Ethernet padding and FCS are never forwarded.
//   DRAIN/DROP: ignore bytes until rx_valid low, then IDLE.
//            DRAIN = normal end of frame. DROP = entered on any failed check.
//  Failed field check: enter DROP on the failing byte; pulse frame_drop once.
//  rx_valid low mid-header: return to IDLE and pulse frame_drop.
//  rx_valid low mid-PAYLOAD (truncated frame): udp_data_valid drops the next cycle; pulse frame_drop; go to IDLE.
//   Packer then flushes a partial word. This is the accepted behaviour.
//  Gap rule: udp_data_valid low for >= 2 cycles between datagrams (the packer needs 2 cycles to flush).
//   Enforce by inserting wait cycles in IDLE if a new frame starts early.
//  No backpressure: the block is purely streaming; the packer is never stalled.
//  udp_* outputs are stable from first payload strobe until the next accepted header.
//  Counter: 6-bit, reloaded at each header boundary. Payload counter: 16-bit down-counter.
// STRUCTURE
//  eth_pkg: ETH_HDR_LEN=14, IP_HDR_LEN=20, UDP_HDR_LEN=8, ETHERTYPE_IPV4=16'h0800,
//   IP_PROTO_UDP=8'd17, MAC_BCAST, parser state enum (shared with a future TX builder).
//  Sub-module ip_csum_acc: byte-pair ones-complement accumulator. Ports: clr, byte_en, byte, sum[15:0].
//  Everything else stays in the parser FSM.
// TESTING
//  1. Valid frame, 12-byte payload 01..0C, port 5000, good checksum
//     -> 12 strobes 01..0C, 1-cycle latency; udp_pay_len=12; no frame_drop.
//  2. Same frame, wrong dest port 5001 -> zero strobes, one frame_drop pulse; udp_* outputs unchanged.
//  3. Header checksum corrupted, CHECK_CSUM=1 -> dropped, one pulse.
//     Same frame with CHECK_CSUM=0 -> payload forwarded.
//  4. Payload 5 bytes inside a 60-byte padded frame plus FCS
//     -> exactly 5 strobes; padding and FCS not forwarded.
//  5. Two back-to-back frames, 1-cycle rx gap -> two bursts separated by >= 2 low cycles of udp_data_valid.
//  6. rx_valid cut after 3 of 8 payload bytes
//     -> 3 strobes, then frame_drop; next valid frame parsed correctly.
//     Also assert aresetn mid-payload -> all outputs 0 immediately.

Source files
------------

// File: rtl/udp_rx_parser_pkg.sv
// Shared Ethernet/IPv4/UDP constants, parser state codes and a ones-complement adder.
// Also intended for a future TX header builder.
package udp_rx_parser_pkg;

  localparam int          ETH_HDR_LEN    = 14;
  localparam int          IP_HDR_LEN     = 20;
  localparam int          UDP_HDR_LEN    = 8;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [47:0] MAC_BCAST      = 48'hFFFF_FFFF_FFFF;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ETH_HDR = 3'd1;
  localparam logic [2:0] ST_IP_HDR  = 3'd2;
  localparam logic [2:0] ST_UDP_HDR = 3'd3;
  localparam logic [2:0] ST_PAYLOAD = 3'd4;
  localparam logic [2:0] ST_DRAIN   = 3'd5;
  localparam logic [2:0] ST_DROP    = 3'd6;

  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/udp_rx_parser_if.sv
// MAC byte stream in, UDP payload bytes and datagram metadata out.
// master = MAC side driving rx_*, slave = parser.
interface udp_rx_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  data_out;
  logic        udp_data_valid;
  logic [31:0] udp_src_ip;
  logic [15:0] udp_src_port;
  logic [15:0] udp_pay_len;
  logic        frame_drop;

  modport master (
    output rx_data, rx_valid,
    input  data_out, udp_data_valid, udp_src_ip, udp_src_port, udp_pay_len, frame_drop
  );

  modport slave (
    input  rx_data, rx_valid,
    output data_out, udp_data_valid, udp_src_ip, udp_src_port, udp_pay_len, frame_drop
  );
endinterface

// File: rtl/udp_rx_parser_ip_csum_acc.sv
// Byte-pair ones-complement accumulator; sum_o reflects completed 16-bit words one cycle
// after the second byte of each pair. No backpressure.
module ip_csum_acc
  import udp_rx_parser_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] sum_o
);
  logic [15:0] sum_q, sum_d;
  logic [7:0]  hi_q, hi_d;
  logic        odd_q, odd_d;

  always_comb begin
    sum_d = sum_q;
    hi_d  = hi_q;
    odd_d = odd_q;
    if (clr_i) begin
      sum_d = '0;
      hi_d  = '0;
      odd_d = 1'b0;
    end else if (byte_en_i) begin
      if (odd_q) begin
        sum_d = oc_add(sum_q, {hi_q, byte_i});
        odd_d = 1'b0;
      end else begin
        hi_d  = byte_i;
        odd_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sum_q <= '0;
      hi_q  <= '0;
      odd_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      hi_q  <= hi_d;
      odd_q <= odd_d;
    end
  end

  assign sum_o = sum_q;
endmodule

// File: rtl/udp_rx_parser.sv
// Ethernet II / IPv4 / UDP receive filter forwarding only the datagram payload.
// Payload out 1 cycle after the rx byte; purely streaming, no backpressure.
module udp_rx_parser
  import udp_rx_parser_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0164,
  parameter logic [15:0] LOCAL_PORT = 16'd5000,
  parameter bit          CHECK_CSUM = 1'b1
) (
  input logic            aclk,
  input logic            aresetn,
  udp_rx_parser_if.slave bus
);
  logic [2:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ucast_q, ucast_d, bcast_q, bcast_d;
  logic [15:0] tot_len_q, tot_len_d, udp_len_q, udp_len_d, pay_cnt_q, pay_cnt_d;
  logic [31:0] sip_sh_q, sip_sh_d, sip_q, sip_d;
  logic [15:0] sport_sh_q, sport_sh_d, sport_q, sport_d, plen_q, plen_d;
  logic [7:0]  dout_q, dout_d;
  logic        dvld_q, dvld_d, drop_q, drop_d;
  logic        csum_clr, csum_en, bad;
  logic [15:0] csum_sum, ulen;
  logic [7:0]  mac_b, ip_b, port_b;

  // Expected byte of each local address for the current header offset.
  assign mac_b  = 8'(LOCAL_MAC >> (6'd40 - {cnt_q[2:0], 3'b000}));
  assign ip_b   = 8'(LOCAL_IP >> {~cnt_q[1:0], 3'b000});
  assign port_b = 8'(LOCAL_PORT >> {~cnt_q[0], 3'b000});
  assign ulen   = {udp_len_q[7:0], bus.rx_data};

  ip_csum_acc u_csum (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .clr_i     (csum_clr),
    .byte_en_i (csum_en),
    .byte_i    (bus.rx_data),
    .sum_o     (csum_sum)
  );

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  ucast_d = ucast_q;  bcast_d = bcast_q;
    tot_len_d = tot_len_q;  udp_len_d = udp_len_q;  pay_cnt_d = pay_cnt_q;
    sip_sh_d = sip_sh_q;  sport_sh_d = sport_sh_q;
    sip_d = sip_q;  sport_d = sport_q;  plen_d = plen_q;
    dout_d = dout_q;  dvld_d = 1'b0;  drop_d = 1'b0;
    csum_clr = 1'b0;  csum_en = 1'b0;  bad = 1'b0;
    case (state_q)
      ST_IDLE: begin
        csum_clr = 1'b1;
        if (bus.rx_valid) begin
          ucast_d = (bus.rx_data == LOCAL_MAC[47:40]);
          bcast_d = (bus.rx_data == MAC_BCAST[47:40]);
          bad     = (bus.rx_data != LOCAL_MAC[47:40]) && (bus.rx_data != MAC_BCAST[47:40]);
          cnt_d   = 6'd1;
          state_d = ST_ETH_HDR;
        end
      end
      ST_ETH_HDR: begin
        if (!bus.rx_valid) begin
          state_d = ST_IDLE;
          drop_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q < 6'd6) begin
            ucast_d = ucast_q && (bus.rx_data == mac_b);
            bcast_d = bcast_q && (bus.rx_data == MAC_BCAST[7:0]);
            bad     = !(ucast_q && (bus.rx_data == mac_b)) &&
                      !(bcast_q && (bus.rx_data == MAC_BCAST[7:0]));
          end else if (cnt_q == 6'd12) begin
            bad = (bus.rx_data != ETHERTYPE_IPV4[15:8]);
          end else if (cnt_q == 6'(ETH_HDR_LEN - 1)) begin
            bad     = (bus.rx_data != ETHERTYPE_IPV4[7:0]);
            cnt_d   = '0;
            state_d = ST_IP_HDR;
          end
        end
      end
      ST_IP_HDR: begin
        if (!bus.rx_valid) begin
          state_d = ST_IDLE;
          drop_d  = 1'b1;
        end else begin
          csum_en = 1'b1;
          cnt_d   = cnt_q + 6'd1;
          case (cnt_q)
            6'd0:                   bad = (bus.rx_data != 8'h45);
            6'd2, 6'd3:             tot_len_d = {tot_len_q[7:0], bus.rx_data};
            6'd6:                   bad = (bus.rx_data[5:0] != 6'd0);  // MF + offset high bits
            6'd7:                   bad = (bus.rx_data != 8'd0);
            6'd9:                   bad = (bus.rx_data != IP_PROTO_UDP);
            6'd12, 6'd13, 6'd14, 6'd15: sip_sh_d = {sip_sh_q[23:0], bus.rx_data};
            6'd16, 6'd17, 6'd18:    bad = (bus.rx_data != ip_b);
            6'(IP_HDR_LEN - 1): begin
              bad     = (bus.rx_data != ip_b);
              cnt_d   = '0;
              state_d = ST_UDP_HDR;
            end
            default: ;
          endcase
        end
      end
      ST_UDP_HDR: begin
        if (!bus.rx_valid) begin
          state_d = ST_IDLE;
          drop_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
          case (cnt_q)
            // Accumulator holds the full IP header sum one byte after the header ends.
            6'd0: begin
              sport_sh_d = {sport_sh_q[7:0], bus.rx_data};
              bad        = CHECK_CSUM && (csum_sum != 16'hFFFF);
            end
            6'd1:       sport_sh_d = {sport_sh_q[7:0], bus.rx_data};
            6'd2, 6'd3: bad = (bus.rx_data != port_b);
            6'd4:       udp_len_d = ulen;
            6'd5: begin
              udp_len_d = ulen;
              bad = (ulen < 16'(UDP_HDR_LEN)) || (({1'b0, ulen} + 17'(IP_HDR_LEN)) > {1'b0, tot_len_q});
            end
            6'(UDP_HDR_LEN - 1): begin
              sip_d     = sip_sh_q;
              sport_d   = sport_sh_q;
              plen_d    = udp_len_q - 16'(UDP_HDR_LEN);
              pay_cnt_d = udp_len_q - 16'(UDP_HDR_LEN);
              state_d   = (udp_len_q == 16'(UDP_HDR_LEN)) ? ST_DRAIN : ST_PAYLOAD;
            end
            default: ;
          endcase
        end
      end
      ST_PAYLOAD: begin
        if (bus.rx_valid) begin
          dout_d    = bus.rx_data;
          dvld_d    = 1'b1;
          pay_cnt_d = pay_cnt_q - 16'd1;
          if (pay_cnt_q == 16'd1) state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
          drop_d  = 1'b1;
        end
      end
      ST_DRAIN, ST_DROP: begin
        if (!bus.rx_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // The 42-byte header guarantees the inter-datagram strobe gap, so IDLE never stalls.
    if (bad) begin
      state_d = ST_DROP;
      drop_d  = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;  cnt_q <= '0;  ucast_q <= 1'b0;  bcast_q <= 1'b0;
      tot_len_q <= '0;  udp_len_q <= '0;  pay_cnt_q <= '0;
      sip_sh_q <= '0;  sport_sh_q <= '0;  sip_q <= '0;  sport_q <= '0;  plen_q <= '0;
      dout_q <= '0;  dvld_q <= 1'b0;  drop_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  ucast_q <= ucast_d;  bcast_q <= bcast_d;
      tot_len_q <= tot_len_d;  udp_len_q <= udp_len_d;  pay_cnt_q <= pay_cnt_d;
      sip_sh_q <= sip_sh_d;  sport_sh_q <= sport_sh_d;  sip_q <= sip_d;  sport_q <= sport_d;
      plen_q <= plen_d;  dout_q <= dout_d;  dvld_q <= dvld_d;  drop_q <= drop_d;
    end
  end

  assign bus.data_out       = dout_q;
  assign bus.udp_data_valid = dvld_q;
  assign bus.udp_src_ip     = sip_q;
  assign bus.udp_src_port   = sport_q;
  assign bus.udp_pay_len    = plen_q;
  assign bus.frame_drop     = drop_q;
endmodule
